// File: rtl/lidar_pkg.sv
// ============================================================================
// Module : lidar_pkg
// Brief  : Shared types and Q16.16 constants for the LiDAR bounding-box path.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package lidar_pkg;

  localparam int COORD_W_DEF = 32;
  localparam int CNT_W_DEF   = 16;
  localparam int MIN_PTS_DEF = 1;

  typedef logic signed [COORD_W_DEF-1:0] coord_t;

  typedef struct packed {
    coord_t min_x;
    coord_t min_y;
    coord_t min_z;
    coord_t max_x;
    coord_t max_y;
    coord_t max_z;
  } bbox_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } acc_state_t;

  localparam coord_t Q_ONE  = 32'sh0001_0000;
  localparam coord_t Q_HALF = 32'sh0000_8000;

  // Integer to Q16.16
  function automatic coord_t q16(input int i);
    return coord_t'(i) <<< 16;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lidar_bbox_accumulator_if.sv
// ============================================================================
// Module : lidar_bbox_accumulator_if
// Brief  : Point-in / box-out handshake bundle for the bounding-box accumulator.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface lidar_bbox_accumulator_if #(
  parameter int COORD_W = 32,
  parameter int CNT_W   = 16
);

  logic                      pt_valid;
  logic                      pt_ready;
  logic signed [COORD_W-1:0] pt_x;
  logic signed [COORD_W-1:0] pt_y;
  logic signed [COORD_W-1:0] pt_z;
  logic                      pt_last;
  logic                      flush;
  logic                      box_valid;
  logic                      box_ready;
  logic signed [COORD_W-1:0] min_x;
  logic signed [COORD_W-1:0] min_y;
  logic signed [COORD_W-1:0] min_z;
  logic signed [COORD_W-1:0] max_x;
  logic signed [COORD_W-1:0] max_y;
  logic signed [COORD_W-1:0] max_z;
  logic [CNT_W-1:0]          pt_count;
  logic                      box_error;

  modport master (
    output pt_valid, pt_x, pt_y, pt_z, pt_last, flush, box_ready,
    input  pt_ready, box_valid, min_x, min_y, min_z, max_x, max_y, max_z,
           pt_count, box_error
  );

  modport slave (
    input  pt_valid, pt_x, pt_y, pt_z, pt_last, flush, box_ready,
    output pt_ready, box_valid, min_x, min_y, min_z, max_x, max_y, max_z,
           pt_count, box_error
  );

endinterface

`default_nettype wire

// File: rtl/bbox_axis_tracker.sv
// ============================================================================
// Module : bbox_axis_tracker
// Brief  : One axis signed min/max register pair with load and update enables.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bbox_axis_tracker #(
  parameter int COORD_W = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load_i,
  input  logic                      upd_i,
  input  logic signed [COORD_W-1:0] pt_i,
  output logic signed [COORD_W-1:0] min_o,
  output logic signed [COORD_W-1:0] max_o
);

  logic signed [COORD_W-1:0] min_q, min_d;
  logic signed [COORD_W-1:0] max_q, max_d;

  // Strict compares so ties leave the register untouched
  always_comb begin
    min_d = min_q;
    max_d = max_q;
    if (load_i) begin
      min_d = pt_i;
      max_d = pt_i;
    end else if (upd_i) begin
      if (pt_i < min_q) min_d = pt_i;
      if (pt_i > max_q) max_d = pt_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      min_q <= '0;
      max_q <= '0;
    end else begin
      min_q <= min_d;
      max_q <= max_d;
    end
  end

  assign min_o = min_q;
  assign max_o = max_q;

endmodule

`default_nettype wire

// File: rtl/lidar_bbox_accumulator.sv
// ============================================================================
// Module : lidar_bbox_accumulator
// Brief  : Streams one cluster of points, emits its per-axis bounding box.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module lidar_bbox_accumulator
  import lidar_pkg::*;
#(
  parameter int COORD_W = COORD_W_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int MIN_PTS = MIN_PTS_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  lidar_bbox_accumulator_if.slave bus
);

  localparam logic [CNT_W:0] C_MIN_PTS = (CNT_W+1)'(MIN_PTS);

  acc_state_t                state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      sat_q, sat_d;
  logic [CNT_W:0]            cnt_inc;
  logic                      accept;
  logic                      xfer;
  logic                      load;
  logic                      upd;
  logic signed [COORD_W-1:0] pt_a  [3];
  logic signed [COORD_W-1:0] min_a [3];
  logic signed [COORD_W-1:0] max_a [3];

  // Accept term mirrors pt_ready without reading pt_valid back into it
  assign accept = bus.pt_valid && (state_q != HOLD) && !bus.flush;
  assign xfer   = (state_q == HOLD) && bus.box_ready;
  assign load   = accept && (state_q == IDLE);
  assign upd    = accept && (state_q == ACCUM);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bus.flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (accept) state_d = bus.pt_last ? HOLD : ACCUM;
        ACCUM:   if (accept && bus.pt_last) state_d = HOLD;
        HOLD:    if (xfer) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    bus.pt_ready  = (state_q != HOLD) && !bus.flush;
    bus.box_valid = (state_q == HOLD);
    bus.box_error = (state_q == HOLD) && (sat_q || ({1'b0, cnt_q} < C_MIN_PTS));
  end

  // Extra carry bit flags the wrap that saturation must absorb
  always_comb begin
    cnt_inc = {1'b0, cnt_q} + (CNT_W+1)'(1);
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    if (bus.flush) begin
      cnt_d = '0;
      sat_d = 1'b0;
    end else if (load) begin
      cnt_d = CNT_W'(1);
      sat_d = 1'b0;
    end else if (upd) begin
      if (cnt_inc[CNT_W]) sat_d = 1'b1;
      else                cnt_d = cnt_inc[CNT_W-1:0];
    end else if (xfer) begin
      sat_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sat_q <= sat_d;
    end
  end

  assign pt_a[0] = bus.pt_x;
  assign pt_a[1] = bus.pt_y;
  assign pt_a[2] = bus.pt_z;

  for (genvar g = 0; g < 3; g++) begin : g_axis
    bbox_axis_tracker #(
      .COORD_W (COORD_W)
    ) u_trk (
      .clk    (clk),
      .rst    (rst),
      .load_i (load),
      .upd_i  (upd),
      .pt_i   (pt_a[g]),
      .min_o  (min_a[g]),
      .max_o  (max_a[g])
    );
  end

  assign bus.min_x    = min_a[0];
  assign bus.min_y    = min_a[1];
  assign bus.min_z    = min_a[2];
  assign bus.max_x    = max_a[0];
  assign bus.max_y    = max_a[1];
  assign bus.max_z    = max_a[2];
  assign bus.pt_count = cnt_q;

endmodule

`default_nettype wire
